wave_scope_render: RTL



---
 rtl/scope_pkg.sv | 12 +
 rtl/scope_col_ram.sv | 17 +
 rtl/wave_scope_render.sv | 134 +++++++++++++
 3 files changed

// File: rtl/scope_pkg.sv
// scope_pkg: capture states, colours and plot geometry shared by the waveform scope.
package scope_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE} cap_state_e;
  localparam int DEF_PLOT_X0 = 64;
  localparam int DEF_PLOT_Y0 = 112;
  localparam int DEF_PLOT_W = 512;
  localparam int DEF_PLOT_H = 256;
  localparam int DEF_DATA_LAT = 3;
  localparam logic [23:0] DEF_TRACE_RGB = 24'hFFFF00;
  localparam logic [23:0] DEF_PLOT_RGB = 24'h000040;
  localparam logic [23:0] DEF_BG_RGB = 24'h000000;
endpackage

// File: rtl/scope_col_ram.sv
// scope_col_ram: simple dual-port column RAM, sync write, registered read; bank bit is the address MSB.
module scope_col_ram #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [2**AW];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/wave_scope_render.sv
// wave_scope_render: captures one line of DDS samples per frame and draws them as a trace in a plot window.
// Optional WAVE_FREEZE_EN adds a freeze input that holds the displayed frame.
module wave_scope_render
  import scope_pkg::*;
#(
  parameter int          PLOT_X0   = DEF_PLOT_X0,
  parameter int          PLOT_Y0   = DEF_PLOT_Y0,
  parameter int          PLOT_W    = DEF_PLOT_W,
  parameter int          PLOT_H    = DEF_PLOT_H,
  parameter int          DATA_LAT  = DEF_DATA_LAT,
  parameter logic [23:0] TRACE_RGB = DEF_TRACE_RGB,
  parameter logic [23:0] PLOT_RGB  = DEF_PLOT_RGB,
  parameter logic [23:0] BG_RGB    = DEF_BG_RGB
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        vga_hs_in,
  input  logic        vga_vs_in,
  input  logic        vga_de_in,
  input  logic [11:0] pix_x,
  input  logic [11:0] pix_y,
  input  logic        region_active,
  input  logic        pos_de,
  input  logic [7:0]  data_in,
`ifdef WAVE_FREEZE_EN
  input  logic        freeze,
`endif
  output logic [23:0] rgb_out,
  output logic        vga_hs_out,
  output logic        vga_vs_out,
  output logic        vga_de_out,
  output logic        frame_swapped
);
  localparam int CW = $clog2(PLOT_W);
  cap_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic bank_q, bank_d, disp_vld_q, swap_d, wr_en, frz, vs_prev_q, vs_rise, cap_vld;
  logic [DATA_LAT-1:0] cap_pipe_q;
`ifdef WAVE_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif
  assign vs_rise = vga_vs_in & ~vs_prev_q;
  assign cap_vld = cap_pipe_q[DATA_LAT-1];
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    bank_d = bank_q;
    swap_d = 1'b0;
    wr_en = 1'b0;
    case (state_q)
      ST_IDLE: state_d = vs_rise ? ST_ARMED : ST_IDLE;
      ST_DONE: begin
        if (vs_rise) begin
          state_d = ST_ARMED;
          bank_d = bank_q ^ ~frz;
          swap_d = ~frz;
        end
      end
      default: begin
        if (vs_rise) begin
          state_d = ST_ARMED;
          col_d = '0;
        end else if (cap_vld) begin
          wr_en = 1'b1;
          col_d = col_q + 1'b1;
          state_d = (col_q == CW'(PLOT_W - 1)) ? ST_DONE : ST_CAPTURE;
        end
      end
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      col_q <= '0;
      bank_q <= 1'b0;
      disp_vld_q <= 1'b0;
      vs_prev_q <= 1'b0;
      cap_pipe_q <= '0;
      frame_swapped <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      bank_q <= bank_d;
      disp_vld_q <= disp_vld_q | swap_d;
      vs_prev_q <= vga_vs_in;
      cap_pipe_q <= (cap_pipe_q << 1) | DATA_LAT'(region_active & pos_de);
      frame_swapped <= swap_d;
    end
  end
  logic win0;
  logic [CW-1:0] col0;
  logic [7:0] row0, rdata, row1_q, prev_q, s, p, lo, hi;
  logic win1_q, first1_q, vld1_q, de1_q, hs1_q, vs1_q, trace;
  logic [23:0] rgb_d;
  assign win0 = (pix_x >= 12'(PLOT_X0)) && (pix_x < 12'(PLOT_X0 + PLOT_W)) &&
                (pix_y >= 12'(PLOT_Y0)) && (pix_y < 12'(PLOT_Y0 + PLOT_H));
  assign col0 = CW'(pix_x - 12'(PLOT_X0));
  assign row0 = ~8'(pix_y - 12'(PLOT_Y0));
  scope_col_ram #(.AW(CW + 1)) u_ram (
    .clk_i(sys_clk),
    .we_i(wr_en),
    .waddr_i({bank_q, col_q}),
    .wdata_i(data_in),
    .raddr_i({~bank_q, col0}),
    .rdata_o(rdata)
  );
  // the display bank reads as zero until a completed capture has been swapped in
  assign s = vld1_q ? rdata : 8'd0;
  assign p = first1_q ? s : prev_q;
  assign lo = (s < p) ? s : p;
  assign hi = (s < p) ? p : s;
  assign trace = (row1_q >= lo) && (row1_q <= hi);
  assign rgb_d = !de1_q ? 24'd0 : !win1_q ? BG_RGB : trace ? TRACE_RGB : PLOT_RGB;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      {win1_q, first1_q, vld1_q, de1_q, hs1_q, vs1_q} <= '0;
      row1_q <= '0;
      prev_q <= '0;
      rgb_out <= '0;
      {vga_hs_out, vga_vs_out, vga_de_out} <= '0;
    end else begin
      win1_q <= win0;
      first1_q <= (col0 == '0);
      vld1_q <= disp_vld_q;
      row1_q <= row0;
      {hs1_q, vs1_q, de1_q} <= {vga_hs_in, vga_vs_in, vga_de_in};
      if (win1_q) prev_q <= s;
      rgb_out <= rgb_d;
      {vga_hs_out, vga_vs_out, vga_de_out} <= {hs1_q, vs1_q, de1_q};
    end
  end
endmodule
